// File: rtl/elevator_button_conditioner.sv
// Conditions seven raw elevator call/select buttons: two-flop synchronizer,
// symmetric debounce, single-cycle press pulse and per-bit stuck reporting.
module elevator_button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STUCK_CYCLES    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] btn_raw,
  output logic [6:0] btn_pulse,
  output logic [6:0] btn_level,
  output logic [6:0] btn_stuck,
  output logic       any_stuck
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(STUCK_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(STUCK_CYCLES);

  logic [6:0] s1;
  logic [6:0] s2;

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 7; gi++) begin : g_bit
      logic          stable;
      logic [CW-1:0] cnt;
      logic [HW-1:0] hold_cnt;
      logic          pulse;
      logic          stuck;
      logic          accept;

      // A new level is taken only after it has survived a full count.
      assign accept = (s2[gi] != stable) && (cnt == CNT_LAST);

      always_ff @(posedge clk) begin
        if (!rst) begin
          stable   <= 1'b0;
          cnt      <= '0;
          hold_cnt <= '0;
          pulse    <= 1'b0;
          stuck    <= 1'b0;
        end else begin
          pulse <= accept && s2[gi];

          if (s2[gi] == stable) begin
            cnt <= '0;
          end else if (accept) begin
            stable <= s2[gi];
            cnt    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end

          // Debounced release clears the hold tracking on the same edge.
          if (accept && !s2[gi]) begin
            hold_cnt <= '0;
            stuck    <= 1'b0;
          end else if (stable) begin
            if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
            if (hold_cnt == HOLD_MAX) stuck <= 1'b1;
          end
        end
      end

      assign btn_level[gi] = stable;
      assign btn_pulse[gi] = pulse;
      assign btn_stuck[gi] = stuck;
    end
  endgenerate

  assign any_stuck = |btn_stuck;

endmodule

// File: tb/tb_elevator_button_conditioner.sv
// Directed bench for elevator_button_conditioner: the driver queues the
// expected output word after every edge, a monitor pops and compares it.
module tb_elevator_button_conditioner;

  localparam int DB = 4;
  localparam int ST = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] btn_raw = 7'h00;
  logic [6:0] btn_pulse;
  logic [6:0] btn_level;
  logic [6:0] btn_stuck;
  logic       any_stuck;

  elevator_button_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .STUCK_CYCLES   (ST)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .btn_pulse(btn_pulse),
    .btn_level(btn_level),
    .btn_stuck(btn_stuck),
    .any_stuck(any_stuck)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard
  logic [21:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          passed = 0;
  logic [21:0] mon_e;
  logic [21:0] mon_a;
  string       mon_n;

  function automatic logic [21:0] pack(input logic [6:0] p, input logic [6:0] l,
                                       input logic [6:0] s);
    return {|s, s, l, p};
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_n = name_q.pop_front();
      mon_a = {any_stuck, btn_stuck, btn_level, btn_pulse};
      checks++;
      if (mon_a === mon_e) passed++;
      else $display("FAIL %s @%0t: got any/stuck/level/pulse=%h required %h",
                    mon_n, $time, mon_a, mon_e);
    end
  end

  // driver: apply inputs, clock one edge, queue the state expected after it
  task automatic cyc(input logic r, input logic [6:0] raw, input logic [6:0] p,
                     input logic [6:0] l, input logic [6:0] s, input string nm);
    rst     = r;
    btn_raw = raw;
    @(posedge clk);
    exp_q.push_back(pack(p, l, s));
    name_q.push_back(nm);
    #1;
  endtask

  initial begin
    // reset with all buttons pressed, then held through release of reset
    for (int j = 0; j < 3; j++) cyc(1'b0, 7'h7F, 7'h00, 7'h00, 7'h00, "reset_hold");
    for (int j = 0; j < 8; j++)
      cyc(1'b1, 7'h7F, (j == 5) ? 7'h7F : 7'h00, (j >= 5) ? 7'h7F : 7'h00, 7'h00,
          "held_through_reset");
    for (int j = 0; j < 7; j++)
      cyc(1'b1, 7'h00, 7'h00, (j < 5) ? 7'h7F : 7'h00, 7'h00, "release_all");

    // clean press and release on bit 0
    for (int j = 0; j < 8; j++)
      cyc(1'b1, 7'h01, (j == 5) ? 7'h01 : 7'h00, (j >= 5) ? 7'h01 : 7'h00, 7'h00,
          "press_bit0");
    for (int j = 0; j < 7; j++)
      cyc(1'b1, 7'h00, 7'h00, (j < 5) ? 7'h01 : 7'h00, 7'h00, "release_bit0");

    // three-cycle glitch on bit 4 is filtered out
    for (int j = 0; j < 10; j++)
      cyc(1'b1, (j < 3) ? 7'h10 : 7'h00, 7'h00, 7'h00, 7'h00, "glitch_bit4");

    // bouncing press then bouncing release on bit 5
    for (int j = 0; j < 13; j++)
      cyc(1'b1, (j < 4) ? ((j % 2 == 0) ? 7'h20 : 7'h00) : 7'h20,
          (j == 9) ? 7'h20 : 7'h00, (j >= 9) ? 7'h20 : 7'h00, 7'h00, "bounce_press_bit5");
    for (int j = 0; j < 13; j++)
      cyc(1'b1, (j < 4) ? ((j % 2 == 1) ? 7'h20 : 7'h00) : 7'h00,
          7'h00, (j < 9) ? 7'h20 : 7'h00, 7'h00, "bounce_release_bit5");

    // long hold on bit 6 trips the stuck flag; release clears it with the level
    for (int j = 0; j < 40; j++)
      cyc(1'b1, 7'h40, (j == 5) ? 7'h40 : 7'h00, (j >= 5) ? 7'h40 : 7'h00,
          (j >= 22) ? 7'h40 : 7'h00, "stuck_hold_bit6");
    for (int j = 0; j < 8; j++)
      cyc(1'b1, 7'h00, 7'h00, (j < 5) ? 7'h40 : 7'h00, (j < 5) ? 7'h40 : 7'h00,
          "stuck_release_bit6");

    // simultaneous press of bits 2 and 3
    for (int j = 0; j < 8; j++)
      cyc(1'b1, 7'h0C, (j == 5) ? 7'h0C : 7'h00, (j >= 5) ? 7'h0C : 7'h00, 7'h00,
          "simul_press");
    for (int j = 0; j < 7; j++)
      cyc(1'b1, 7'h00, 7'h00, (j < 5) ? 7'h0C : 7'h00, 7'h00, "simul_release");

    // reset mid-count restarts the full press latency
    for (int j = 0; j < 13; j++)
      cyc((j != 3), 7'h0C, (j == 9) ? 7'h0C : 7'h00, (j >= 9) ? 7'h0C : 7'h00, 7'h00,
          "midcount_reset");
    for (int j = 0; j < 7; j++)
      cyc(1'b1, 7'h00, 7'h00, (j < 5) ? 7'h0C : 7'h00, 7'h00, "midcount_release");

    // reset landing on the pulse edge suppresses the pulse
    for (int j = 0; j < 10; j++)
      cyc((j != 5), (j < 5) ? 7'h01 : 7'h00, 7'h00, 7'h00, 7'h00, "pulse_cycle_reset");

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL drain: got %0d pending entries required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "timeout");
  end

endmodule
